// File: rtl/divmul_pkg.sv
// Shared types and constants for the divide-then-multiply FIFO engine.
// Optional build macro FIFO_FWFT_EN is consumed by the FIFO and the top level.
package divmul_pkg;

  localparam int DATA_W   = 16;
  localparam int OPND_W   = 8;
  localparam int DIV_ITER = 8;

  // RD is only reachable in the registered-read build.
  typedef enum logic [2:0] {
    IDLE,
    RD,
    DIV,
    FIX,
    MUL,
    DONE
  } state_e;

endpackage

// File: rtl/divmul_fifo_engine_if.sv
// Producer-facing bundle of the divmul engine: operand pushes in, results out.
interface divmul_fifo_engine_if;
  import divmul_pkg::*;

  // Handshake: a word is taken on a rising edge where write_req=1 and full_out=0;
  // with full_out=1 the word is dropped and the producer must hold or retry.
  // done_sig is a one-cycle strobe qualifying product, which then holds its value.
  logic              write_req;
  logic [DATA_W-1:0] fifo_write_data;
  logic              full_out;
  logic              done_sig;
  logic [DATA_W-1:0] product;

  modport master (
    output write_req,
    output fifo_write_data,
    input  full_out,
    input  done_sig,
    input  product
  );

  modport slave (
    input  write_req,
    input  fifo_write_data,
    output full_out,
    output done_sig,
    output product
  );

endinterface

// File: rtl/divmul_sync_fifo.sv
// Single-clock operand FIFO with registered full flag and wrapping pointers.
// FIFO_FWFT_EN selects first-word-fall-through reads; otherwise reads are registered.
module divmul_sync_fifo
  import divmul_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_req,
  input  logic              pop_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       count;
  logic [AW:0]       count_next;
  logic              push;
  logic              pop;

  // A full FIFO refuses writes even when a pop frees a slot in the same cycle.
  assign push  = push_req && !full;
  assign pop   = pop_req && !empty;
  assign empty = (count == '0);

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (!push && pop) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count_next;
      full  <= (count_next == DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

`ifdef FIFO_FWFT_EN
  assign rd_data = mem[rptr];
`else
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (pop) begin
      rd_q <= mem[rptr];
    end
  end

  assign rd_data = rd_q;
`endif

endmodule

// File: rtl/divmul_fifo_engine.sv
// Pops {dividend, divisor} words, does a signed 8-bit divide, outputs quotient*remainder.
// FIFO_FWFT_EN: fall-through FIFO, operands latched in IDLE and the RD state is skipped.
module divmul_fifo_engine
  import divmul_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  divmul_fifo_engine_if.slave  bus,
  output state_e               state_dbg
);

  localparam logic [2:0] ITER_LAST = 3'(DIV_ITER - 1);

  state_e            state;
  logic              pop_req;
  logic              load_ops;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;

  logic [OPND_W-1:0] op_dvd;
  logic [OPND_W-1:0] op_dsr;
  logic [OPND_W-1:0] op_dvd_mag;
  logic [OPND_W-1:0] op_dsr_mag;
  logic              op_dvd_neg;
  logic              op_dsr_neg;
  logic              op_dsr_zero;

  logic [OPND_W-1:0] dvd_sh;
  logic [OPND_W-1:0] dsr_mag;
  logic [OPND_W-1:0] rem;
  logic [OPND_W-1:0] quo;
  logic [OPND_W-1:0] q_s;
  logic [OPND_W-1:0] r_s;
  logic              dvd_neg;
  logic              dsr_neg;
  logic [2:0]        iter;

  logic [OPND_W:0]   rem_shift;
  logic [OPND_W-1:0] rem_sub;
  logic              rem_ge;
  logic [DATA_W-1:0] mul_res;
  logic [DATA_W-1:0] product_r;
  logic              done_r;

  divmul_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_req (bus.write_req),
    .pop_req  (pop_req),
    .wr_data  (bus.fifo_write_data),
    .rd_data  (fifo_rd_data),
    .full     (bus.full_out),
    .empty    (fifo_empty)
  );

  // Magnitudes are unsigned 8-bit, so |-128| = 8'h80 is still exact.
  assign op_dvd      = fifo_rd_data[DATA_W-1:OPND_W];
  assign op_dsr      = fifo_rd_data[OPND_W-1:0];
  assign op_dvd_neg  = op_dvd[OPND_W-1];
  assign op_dsr_neg  = op_dsr[OPND_W-1];
  assign op_dsr_zero = (op_dsr == '0);
  assign op_dvd_mag  = op_dvd_neg ? (8'd0 - op_dvd) : op_dvd;
  assign op_dsr_mag  = op_dsr_neg ? (8'd0 - op_dsr) : op_dsr;

  assign pop_req = (state == IDLE) && !fifo_empty;
`ifdef FIFO_FWFT_EN
  assign load_ops = pop_req;
`else
  assign load_ops = (state == RD);
`endif

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign rem_shift = {rem, dvd_sh[OPND_W-1]};
  assign rem_ge    = (rem_shift >= {1'b0, dsr_mag});
  assign rem_sub   = rem_shift[OPND_W-1:0] - dsr_mag;
  assign mul_res   = DATA_W'($signed(q_s)) * DATA_W'($signed(r_s));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      done_r    <= 1'b0;
      product_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
`ifdef FIFO_FWFT_EN
            state <= op_dsr_zero ? FIX : DIV;
`else
            state <= RD;
`endif
          end
        end
        RD:   state <= op_dsr_zero ? FIX : DIV;
        DIV:  if (iter == ITER_LAST) state <= FIX;
        FIX:  state <= MUL;
        MUL: begin
          product_r <= mul_res;
          done_r    <= 1'b1;
          state     <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A zero divisor preloads rem with |dividend| and quo with 0, so FIX
  // yields q=0 and r=dividend without a special case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_neg <= 1'b0;
      dsr_neg <= 1'b0;
      dvd_sh  <= '0;
      dsr_mag <= '0;
      rem     <= '0;
      quo     <= '0;
      iter    <= '0;
      q_s     <= '0;
      r_s     <= '0;
    end else if (load_ops) begin
      dvd_neg <= op_dvd_neg;
      dsr_neg <= op_dsr_neg;
      dvd_sh  <= op_dvd_mag;
      dsr_mag <= op_dsr_mag;
      rem     <= op_dsr_zero ? op_dvd_mag : '0;
      quo     <= '0;
      iter    <= '0;
    end else begin
      case (state)
        DIV: begin
          rem    <= rem_ge ? rem_sub : rem_shift[OPND_W-1:0];
          quo    <= {quo[OPND_W-2:0], rem_ge};
          dvd_sh <= {dvd_sh[OPND_W-2:0], 1'b0};
          iter   <= iter + 3'd1;
        end
        FIX: begin
          q_s <= (dvd_neg ^ dsr_neg) ? (8'd0 - quo) : quo;
          r_s <= dvd_neg ? (8'd0 - rem) : rem;
        end
        default: ;
      endcase
    end
  end

  assign bus.done_sig = done_r;
  assign bus.product  = product_r;
  assign state_dbg    = state;

endmodule

// File: tb/tb_divmul_fifo_engine.sv
// Self-checking bench for divmul_fifo_engine: directed spec cases, random words,
// FIFO overflow burst and mid-divide reset, scored against an arithmetic model.
module tb_divmul_fifo_engine;
  import divmul_pkg::*;

`ifdef FIFO_FWFT_EN
  localparam int EXP_LAT = 11;
`else
  localparam int EXP_LAT = 12;
`endif

  logic   clk;
  logic   rst_n;
  state_e state_dbg;

  divmul_fifo_engine_if bus ();

  divmul_fifo_engine #(
    .FIFO_DEPTH (16),
    .FIFO_AW    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_checks   = 0;
  int n_errors   = 0;
  int done_count = 0;
  logic prev_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: truncating signed division, remainder follows the dividend,
  // quotient kept as signed 8 bits, result = q*r as 16 bits; /0 gives 0.
  function automatic logic [15:0] ref_product(input logic [15:0] w);
    int a, b, q, r;
    logic signed [7:0]  q8, r8;
    logic signed [15:0] p;
    a = int'($signed(w[15:8]));
    b = int'($signed(w[7:0]));
    if (b == 0) return 16'h0000;
    q  = a / b;
    r  = a % b;
    q8 = q[7:0];
    r8 = r[7:0];
    p  = q8 * r8;
    return p;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done_sig) begin
        done_count++;
        check("done_width", 32'(prev_done), 32'd0);
        if (exp_q.size() == 0) check("spurious_done", 32'(exp_q.size()), 32'd1);
        else                   check("product", 32'(bus.product), 32'(exp_q.pop_front()));
      end
      prev_done = bus.done_sig;
    end else begin
      prev_done = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [15:0] w, input logic [15:0] e, input bit accept);
    bus.write_req       = 1'b1;
    bus.fifo_write_data = w;
    if (accept) exp_q.push_back(e);
    @(negedge clk);
    bus.write_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [15:0] rand_word(input bit nonzero_div);
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 7))
      0:       w[7:0]  = 8'h00;
      1:       w[15:8] = 8'h80;
      default: ;
    endcase
    if (nonzero_div && w[7:0] == 8'h00) w[7:0] = 8'd3;
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int n;
    int saved_done;
    logic [15:0] w;

    bus.write_req       = 1'b0;
    bus.fifo_write_data = '0;
    rst_n               = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("rst_full", 32'(bus.full_out), 32'd0);
    check("rst_done", 32'(bus.done_sig), 32'd0);
    check("rst_product", 32'(bus.product), 32'd0);
    repeat (30) @(negedge clk);
    check("idle_no_done", 32'(done_count), 32'd0);
    check("idle_product", 32'(bus.product), 32'd0);

    // single word and its latency
    push_word({8'd45, 8'd2}, 16'd22, 1'b1);
    lat = 0;
    while (!bus.done_sig && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(EXP_LAT));
    drain();
    check("product_held", 32'(bus.product), 32'd22);

    // back-to-back directed words
    push_word({8'd45, 8'd2},  16'd22,   1'b1);
    push_word({8'd23, 8'd12}, 16'd11,   1'b1);
    push_word({8'd15, 8'hFA}, 16'hFFFA, 1'b1);
    drain();
    push_word({8'hD3, 8'd2},  16'd22,   1'b1);
    push_word({8'd7,  8'd0},  16'h0000, 1'b1);
    push_word({8'h80, 8'd1},  16'h0000, 1'b1);
    push_word({8'h80, 8'hFF}, 16'h0000, 1'b1);
    push_word({8'hF9, 8'd0},  16'h0000, 1'b1);
    drain();

    // random words with gaps that keep the FIFO below full
    for (int i = 0; i < 30; i++) begin
      w = rand_word(1'b0);
      push_word(w, ref_product(w), 1'b1);
      repeat ($urandom_range(7, 19)) @(negedge clk);
    end
    drain();

    // 20-word burst from idle: two pops happen before edge 17, so words
    // 0..17 fill the FIFO to 16 and words 18,19 are dropped
    for (int i = 0; i < 20; i++) begin
      w = rand_word(i < 2);
      push_word(w, ref_product(w), i < 18);
      if (i == 16) check("full_before", 32'(bus.full_out), 32'd0);
      if (i == 17) check("full_rise",   32'(bus.full_out), 32'd1);
    end
    drain();
    check("full_after_drain", 32'(bus.full_out), 32'd0);

    // reset while dividing with words still queued
    push_word({8'd45, 8'd2}, 16'd22, 1'b1);
    drain();
    for (int i = 0; i < 4; i++) begin
      w = rand_word(1'b1);
      push_word(w, ref_product(w), 1'b1);
    end
    n = 0;
    while (state_dbg != DIV && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach_div", 32'(state_dbg == DIV), 32'd1);
    saved_done = done_count;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_done", 32'(bus.done_sig), 32'd0);
    check("midrst_product", 32'(bus.product), 32'd0);
    check("midrst_full", 32'(bus.full_out), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_no_done", 32'(done_count), 32'(saved_done));
    check("post_rst_product", 32'(bus.product), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
